motor_segment_feeder: RTL and testbench

MOTOR_SEGMENT_FEEDER -- requirements
Module: motor_segment_feeder

---
 rtl/motor_segment_feeder_if.sv | 27 ++
 rtl/motor_segment_feeder.sv | 114 +++++++++++
 tb/tb_motor_segment_feeder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/motor_segment_feeder_if.sv
// Segment-feeder bus: enqueue side from the planner, presented head and status to the step generator.
// The feeder takes the slave modport; the producer/consumer side takes master.
interface motor_segment_feeder_if;
  logic        wrEn;
  logic [14:0] wrDivider;
  logic        wrDir;
  logic [13:0] wrSteps;
  logic        abort;
  logic        activeMode;
  logic [14:0] divider;
  logic        moveDir;
  logic [13:0] stepsToGo;
  logic        full;
  logic [2:0]  level;
  logic        busy;
  logic        drained;

  modport slave (
    input  wrEn, wrDivider, wrDir, wrSteps, abort, activeMode,
    output divider, moveDir, stepsToGo, full, level, busy, drained
  );

  modport master (
    output wrEn, wrDivider, wrDir, wrSteps, abort, activeMode,
    input  divider, moveDir, stepsToGo, full, level, busy, drained
  );
endinterface

// File: rtl/motor_segment_feeder.sv
// 4-deep motion segment queue; head is presented 1 cycle after it changes and popped on a rising activeMode.
// Writes are dropped when full (unless popping the same cycle), when steps == 0, or under abort.
module motor_segment_feeder (
  input  logic                  CLK,
  input  logic                  reset,
  motor_segment_feeder_if.slave bus
);

  typedef struct packed {
    logic [14:0] div;
    logic        dir;
    logic [13:0] steps;
  } seg_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  seg_t       r_mem [4];
  seg_t       r_head;
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_level;
  logic       r_act_prev;

  logic       w_pop;
  logic       w_wr;
  logic       w_bypass;
  logic [1:0] w_rd_ptr_nxt;
  logic [2:0] w_level_nxt;
  seg_t       w_wr_seg;
  seg_t       w_head_nxt;

  always_comb begin
    w_wr_seg       = '0;
    // Divider floor of 2 gives the step generator at least two idle clocks before a reload.
    w_wr_seg.div   = (bus.wrDivider < 15'd2) ? 15'd2 : bus.wrDivider;
    w_wr_seg.dir   = bus.wrDir;
    w_wr_seg.steps = bus.wrSteps;

    w_pop        = bus.activeMode & ~r_act_prev & (r_state == PRESENT);
    w_wr         = bus.wrEn & ~bus.abort & (bus.wrSteps != 14'd0) &
                   ((r_level != 3'd4) | w_pop);
    w_rd_ptr_nxt = r_rd_ptr + {1'b0, w_pop};
    w_level_nxt  = r_level + {2'b00, w_wr} - {2'b00, w_pop};

    // The written entry becomes the head when nothing else remains in front of it.
    w_bypass     = w_wr & (r_level == {2'b00, w_pop});
    w_head_nxt   = w_bypass ? w_wr_seg : r_mem[w_rd_ptr_nxt];
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_seg;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_head     <= '0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_level    <= 3'd0;
      r_act_prev <= 1'b0;
    end else begin
      r_act_prev <= bus.activeMode;
      if (bus.abort) begin
        r_state  <= IDLE;
        r_head   <= '0;
        r_wr_ptr <= 2'd0;
        r_rd_ptr <= 2'd0;
        r_level  <= 3'd0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 2'd1;
        end
        r_rd_ptr <= w_rd_ptr_nxt;
        r_level  <= w_level_nxt;
        case (r_state)
          IDLE: begin
            if (w_wr) begin
              r_state <= PRESENT;
              r_head  <= w_wr_seg;
            end
          end
          PRESENT: begin
            if (w_level_nxt == 3'd0) begin
              r_state <= IDLE;
              r_head  <= '0;
            end else begin
              r_head  <= w_head_nxt;
            end
          end
        endcase
      end
    end
  end

  assign bus.divider   = r_head.div;
  assign bus.moveDir   = r_head.dir;
  assign bus.stepsToGo = r_head.steps;
  assign bus.level     = r_level;
  assign bus.full      = (r_level == 3'd4);
  assign bus.busy      = (r_level != 3'd0) | bus.activeMode;
  assign bus.drained   = r_act_prev & ~bus.activeMode & (r_level == 3'd0);

endmodule

// File: tb/tb_motor_segment_feeder.sv
// Bench for motor_segment_feeder: directed scenarios followed by random traffic, checked against a queue model.
module tb_motor_segment_feeder;

  typedef struct packed {
    logic [14:0] div;
    logic        dir;
    logic [13:0] steps;
  } seg_t;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  motor_segment_feeder_if bus ();

  motor_segment_feeder dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  seg_t q[$];
  seg_t loaded[$];
  seg_t expect_order[$];
  bit   m_act_prev;
  bit   gen_on;
  int   gen_cnt;
  int   drained_seen;
  int   tests;
  int   fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [14:0] dv, input logic dr, input logic [13:0] st);
    bus.wrEn      = 1'b1;
    bus.wrDivider = dv;
    bus.wrDir     = dr;
    bus.wrSteps   = st;
  endtask

  function automatic seg_t mk(input logic [14:0] dv, input logic dr, input logic [13:0] st);
    seg_t s;
    s.div   = dv;
    s.dir   = dr;
    s.steps = st;
    return s;
  endfunction

  // Starts and ends one time unit after a rising edge.
  task automatic cycle();
    seg_t h;
    seg_t s;
    int   sz;
    bit   pop;
    if (gen_on) begin
      if (gen_cnt > 0) begin
        gen_cnt--;
        bus.activeMode = (gen_cnt != 0);
      end else if (bus.stepsToGo != 14'd0 && !bus.activeMode) begin
        loaded.push_back(mk(bus.divider, bus.moveDir, bus.stepsToGo));
        gen_cnt        = int'(bus.stepsToGo);
        bus.activeMode = 1'b1;
      end else begin
        bus.activeMode = 1'b0;
      end
    end
    #1;
    chk("drained", 32'(bus.drained), 32'(m_act_prev && !bus.activeMode && q.size() == 0));
    chk("busy_pre", 32'(bus.busy), 32'(q.size() != 0 || bus.activeMode));
    if (bus.drained) drained_seen++;
    @(posedge CLK);
    pop = bus.activeMode && !m_act_prev && q.size() > 0;
    if (bus.abort) begin
      q.delete();
    end else begin
      sz = q.size();
      if (pop) void'(q.pop_front());
      if (bus.wrEn && bus.wrSteps != 14'd0 && (sz < 4 || pop)) begin
        s = mk((bus.wrDivider < 15'd2) ? 15'd2 : bus.wrDivider, bus.wrDir, bus.wrSteps);
        q.push_back(s);
      end
    end
    m_act_prev = bus.activeMode;
    #1;
    h = (q.size() != 0) ? q[0] : '0;
    chk("divider", 32'(bus.divider), 32'(h.div));
    chk("moveDir", 32'(bus.moveDir), 32'(h.dir));
    chk("stepsToGo", 32'(bus.stepsToGo), 32'(h.steps));
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("full", 32'(bus.full), 32'(q.size() == 4));
    chk("busy", 32'(bus.busy), 32'(q.size() != 0 || bus.activeMode));
    bus.wrEn  = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; gen_on = 0; gen_cnt = 0; drained_seen = 0; m_act_prev = 0;
    reset = 1'b0;
    bus.wrEn = 0; bus.wrDivider = '0; bus.wrDir = 0; bus.wrSteps = '0;
    bus.abort = 0; bus.activeMode = 0;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_divider", 32'(bus.divider), 32'd0);
    chk("rst_stepsToGo", 32'(bus.stepsToGo), 32'd0);
    chk("rst_moveDir", 32'(bus.moveDir), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_drained", 32'(bus.drained), 32'd0);
    reset = 1'b1;

    // Single segment, then popped by a rising activeMode, then drained on the fall.
    wr(15'd100, 1'b1, 14'd5); cycle();
    chk("r033_divider", 32'(bus.divider), 32'd100);
    chk("r033_steps", 32'(bus.stepsToGo), 32'd5);
    bus.activeMode = 1'b1; cycle();
    chk("r033_level_after_pop", 32'(bus.level), 32'd0);
    bus.activeMode = 1'b0; cycle();
    chk("r033_drained_seen", 32'(drained_seen), 32'd1);

    // Five writes into a 4-deep queue.
    for (int i = 0; i < 5; i++) begin
      wr(15'(10 + i), 1'(i), 14'(i + 1)); cycle();
      if (i == 3) chk("r034_full", 32'(bus.full), 32'd1);
    end
    chk("r034_level", 32'(bus.level), 32'd4);
    chk("r034_head", 32'(bus.stepsToGo), 32'd1);

    // Pop and write in the same cycle while full, then drain in order.
    wr(15'd777, 1'b1, 14'd9); bus.activeMode = 1'b1; cycle();
    chk("r035_level", 32'(bus.level), 32'd4);
    bus.activeMode = 1'b0; cycle();
    for (int i = 0; i < 4; i++) begin
      bus.activeMode = 1'b1; cycle();
      bus.activeMode = 1'b0; cycle();
    end
    chk("r035_empty", 32'(bus.level), 32'd0);

    // Zero-step write dropped, small dividers clamped.
    wr(15'd50, 1'b0, 14'd0); cycle();
    wr(15'd1, 1'b1, 14'd3); cycle();
    chk("r036_clamp", 32'(bus.divider), 32'd2);
    wr(15'd0, 1'b0, 14'd4); cycle();
    chk("r036_level", 32'(bus.level), 32'd2);
    bus.abort = 1'b1; cycle();

    // Downstream step generator consumes three segments.
    expect_order.delete();
    expect_order.push_back(mk(15'd20, 1'b1, 14'd2));
    expect_order.push_back(mk(15'd30, 1'b0, 14'd3));
    expect_order.push_back(mk(15'd40, 1'b1, 14'd1));
    foreach (expect_order[i]) begin
      wr(expect_order[i].div, expect_order[i].dir, expect_order[i].steps); cycle();
    end
    loaded.delete(); drained_seen = 0; gen_on = 1'b1;
    repeat (40) cycle();
    gen_on = 1'b0;
    chk("r037_loads", 32'(loaded.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < loaded.size()) chk("r037_order", 32'(loaded[i]), 32'(expect_order[i]));
    end
    chk("r037_drained", 32'(drained_seen), 32'd1);

    // Abort with a simultaneous write, then asynchronous reset mid-PRESENT.
    for (int i = 0; i < 3; i++) begin
      wr(15'(60 + i), 1'b0, 14'(7 + i)); cycle();
    end
    chk("r038_level3", 32'(bus.level), 32'd3);
    wr(15'd99, 1'b1, 14'd9); bus.abort = 1'b1; cycle();
    chk("r038_abort_level", 32'(bus.level), 32'd0);
    wr(15'd70, 1'b1, 14'd11); cycle();
    wr(15'd71, 1'b0, 14'd12); cycle();
    #3;
    reset = 1'b0;
    #1;
    chk("r038_async_div", 32'(bus.divider), 32'd0);
    chk("r038_async_steps", 32'(bus.stepsToGo), 32'd0);
    chk("r038_async_level", 32'(bus.level), 32'd0);
    q.delete(); m_act_prev = 0;
    @(posedge CLK);
    #1;
    reset = 1'b1;
    wr(15'd5, 1'b1, 14'd7); cycle();
    chk("r032_first_write", 32'(bus.level), 32'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bus.wrEn       = 1'($urandom_range(0, 1));
      bus.wrDivider  = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 2)) : 15'($urandom);
      bus.wrDir      = 1'($urandom_range(0, 1));
      bus.wrSteps    = ($urandom_range(0, 5) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
      bus.abort      = ($urandom_range(0, 29) == 0);
      bus.activeMode = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
